// File: rtl/cacheline_adapter.sv
// Bridges a cache line interface to a BEAT_W-wide memory burst interface:
// a line read becomes a BEATS-beat burst read, a line write a BEATS-beat burst write.
module cacheline_adapter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  k;
    logic [CNT_W-1:0]  k_next;
    logic [BEAT_W-1:0] wbuf [BEATS];
    logic [BEAT_W-1:0] lbuf [BEATS];

    assign k_next = k + CNT_W'(1);

    // The fill buffer is the line output; partial fills are visible as they land.
    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line_o[g*BEAT_W +: BEAT_W] = lbuf[g];
    end

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            resp_o    <= 1'b0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            address_o <= '0;
            burst_o   <= '0;
            for (int i = 0; i < BEATS; i++) begin
                wbuf[i] <= '0;
                lbuf[i] <= '0;
            end
        end else begin
            resp_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_i || read_i) begin
                        address_o <= address_i & LINE_MASK;
                        k         <= '0;
                        for (int i = 0; i < BEATS; i++) begin
                            wbuf[i] <= line_i[i*BEAT_W +: BEAT_W];
                        end
                        if (write_i) begin
                            state   <= WR_BURST;
                            write_o <= 1'b1;
                            burst_o <= line_i[BEAT_W-1:0];
                        end else begin
                            state   <= RD_BURST;
                            read_o  <= 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        lbuf[k] <= burst_i;
                        k       <= k_next;
                        if (k == LAST) begin
                            state     <= DONE;
                            read_o    <= 1'b0;
                            address_o <= '0;
                            resp_o    <= 1'b1;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        k <= k_next;
                        if (k == LAST) begin
                            state     <= DONE;
                            write_o   <= 1'b0;
                            address_o <= '0;
                            burst_o   <= '0;
                            resp_o    <= 1'b1;
                        end else begin
                            burst_o <= wbuf[k_next];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter: reads, writes, stalls,
// write priority, asynchronous reset mid-burst and back-to-back transfers.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int checks   = 0;
    int failures = 0;
    int resp_cnt = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    cacheline_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output activity mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (resp_o)  resp_cnt++;
        if (read_o)  rd_cnt++;
        if (write_o) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] B1 = {16{4'h1}}, B2 = {16{4'h2}}, B3 = {16{4'h3}}, B4 = {16{4'h4}};
    localparam logic [63:0] B5 = {16{4'h5}}, B6 = {16{4'h6}}, B7 = {16{4'h7}}, B8 = {16{4'h8}};
    localparam logic [63:0] BA = {16{4'hA}}, BB = {16{4'hB}}, BC = {16{4'hC}}, BD = {16{4'hD}};
    localparam logic [63:0] BE = {16{4'hE}}, B9 = {16{4'h9}};

    logic [63:0] beats [4];
    logic        pat   [7];
    int          idx;
    int          resp_snap;

    initial begin
        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        #12;
        chk("rst_resp", resp_o, 0);
        chk("rst_read", read_o, 0);
        chk("rst_write", write_o, 0);
        chk("rst_addr", address_o, 0);
        chk("rst_burst", burst_o, 0);
        chk("rst_line", line_o, 0);
        rst = 1'b1;
        tick();

        // Read with resp_i tied high.
        beats[0] = B1; beats[1] = B2; beats[2] = B3; beats[3] = B4;
        resp_cnt = 0;
        address_i = 32'h0000_1234; read_i = 1'b1; resp_i = 1'b1; burst_i = beats[0];
        tick();
        chk("rd_read_o", read_o, 1);
        chk("rd_addr", address_o, 32'h0000_1220);
        chk("rd_write_o", write_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rd_resp_early", resp_o, 0);
            burst_i = beats[i];
            tick();
        end
        chk("rd_resp", resp_o, 1);
        chk("rd_read_done", read_o, 0);
        chk("rd_addr_done", address_o, 0);
        chk("rd_line", line_o, {B4, B3, B2, B1});
        read_i = 1'b0;
        tick();
        chk("rd_resp_clear", resp_o, 0);
        chk("rd_pulses", resp_cnt, 1);

        // Write with resp_i tied high; write_i dropped mid-burst.
        resp_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        line_i = {BD, BC, BB, BA}; address_i = 32'h8000_0040; write_i = 1'b1;
        tick();
        write_i = 1'b0;
        chk("wr_write_o", write_o, 1);
        chk("wr_addr", address_o, 32'h8000_0040);
        chk("wr_beat0", burst_o, BA);
        tick();
        chk("wr_beat1", burst_o, BB);
        tick();
        chk("wr_beat2", burst_o, BC);
        tick();
        chk("wr_beat3", burst_o, BD);
        chk("wr_resp_early", resp_o, 0);
        tick();
        chk("wr_resp", resp_o, 1);
        chk("wr_burst_done", burst_o, 0);
        chk("wr_write_done", write_o, 0);
        chk("wr_line_held", line_o, {B4, B3, B2, B1});
        tick();
        chk("wr_cycles", wr_cnt, 4);
        chk("wr_no_read", rd_cnt, 0);
        chk("wr_pulses", resp_cnt, 1);

        // Read with stalls; junk on burst_i whenever resp_i is low.
        beats[0] = B5; beats[1] = B6; beats[2] = B7; beats[3] = B8;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        resp_cnt = 0;
        address_i = 32'h0000_00FF; read_i = 1'b1; resp_i = 1'b0; burst_i = BE;
        tick();
        read_i = 1'b0;
        chk("st_addr", address_o, 32'h0000_00E0);
        idx = 0;
        for (int p = 0; p < 7; p++) begin
            resp_i  = pat[p];
            burst_i = pat[p] ? beats[idx] : BE;
            tick();
            if (pat[p]) idx++;
            if (p == 2) chk("st_partial", line_o, {B4, B3, B2, B5});
            if (p == 5) begin
                chk("st_stall_resp", resp_o, 0);
                chk("st_stall_read", read_o, 1);
            end
        end
        resp_i = 1'b0;
        chk("st_resp", resp_o, 1);
        chk("st_line", line_o, {B8, B7, B6, B5});
        tick();
        chk("st_pulses", resp_cnt, 1);

        // Simultaneous read and write: write wins.
        resp_cnt = 0; rd_cnt = 0; wr_cnt = 0;
        line_i = {64'h4, 64'h3, 64'h2, 64'h1}; address_i = 32'h0000_0400;
        read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
        tick();
        read_i = 1'b0; write_i = 1'b0;
        chk("pri_write_o", write_o, 1);
        chk("pri_read_o", read_o, 0);
        chk("pri_beat0", burst_o, 64'h1);
        repeat (4) tick();
        chk("pri_resp", resp_o, 1);
        tick();
        chk("pri_no_read", rd_cnt, 0);
        chk("pri_wr_cycles", wr_cnt, 4);

        // Asynchronous reset after the second read beat.
        address_i = 32'h0000_2000; read_i = 1'b1; resp_i = 1'b1; burst_i = B9;
        tick();
        tick();
        burst_i = BA;
        tick();
        chk("ar_partial", line_o, {B8, B7, BA, B9});
        resp_snap = resp_cnt;
        #2 rst = 1'b0;
        #1;
        chk("ar_read", read_o, 0);
        chk("ar_addr", address_o, 0);
        chk("ar_line", line_o, 0);
        chk("ar_resp", resp_o, 0);
        read_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("ar_no_resp", resp_cnt, resp_snap);
        chk("ar_idle", read_o, 0);

        // Fresh read after reset.
        resp_cnt = 0;
        beats[0] = {16'hB1B1, 16'hB1B1, 16'hB1B1, 16'hB1B1};
        beats[1] = {16'hB2B2, 16'hB2B2, 16'hB2B2, 16'hB2B2};
        beats[2] = {16'hB3B3, 16'hB3B3, 16'hB3B3, 16'hB3B3};
        beats[3] = {16'hB4B4, 16'hB4B4, 16'hB4B4, 16'hB4B4};
        address_i = 32'h0000_301F; read_i = 1'b1; burst_i = beats[0];
        tick();
        chk("pr_addr", address_o, 32'h0000_3000);
        for (int i = 0; i < 4; i++) begin
            burst_i = beats[i];
            tick();
        end
        read_i = 1'b0;
        chk("pr_resp", resp_o, 1);
        chk("pr_line", line_o, {beats[3], beats[2], beats[1], beats[0]});
        tick();

        // Eviction: write held until resp_o, then a read.
        resp_cnt = 0;
        line_i = {B4, B3, B2, B1}; address_i = 32'h0000_0100; write_i = 1'b1;
        repeat (5) tick();
        chk("ev_wr_resp", resp_o, 1);
        write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_0200; burst_i = BC;
        tick();
        chk("ev_idle_read", read_o, 0);
        chk("ev_idle_write", write_o, 0);
        chk("ev_idle_resp", resp_o, 0);
        chk("ev_idle_addr", address_o, 0);
        tick();
        chk("ev_rd_addr", address_o, 32'h0000_0200);
        chk("ev_rd_read", read_o, 1);
        beats[0] = BC; beats[1] = BD; beats[2] = BE; beats[3] = BA;
        for (int i = 0; i < 4; i++) begin
            burst_i = beats[i];
            tick();
        end
        read_i = 1'b0;
        chk("ev_rd_resp", resp_o, 1);
        chk("ev_line", line_o, {BA, BE, BD, BC});
        tick();
        chk("ev_pulses", resp_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
